// File: rtl/deco_pkg.sv
// -----------------------------------------------------------------------------
// deco_pkg
//
// Shared definitions for the one-hot decode sequencer:
//   - state_e      : FSM states of deco_onehot_seq (IDLE, EMIT)
//   - DEC_SINGLE / DEC_SWEEP : values of the in_mode request field
//   - MAX_IN_W     : widest code the helper function supports
//   - onehot()     : code -> one-hot vector, with selectable bit ordering
//
// Handshake semantics used throughout this block (both ports):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds valid and its payload stable until that edge; ready
//   never depends combinationally on the valid of the same port.
// -----------------------------------------------------------------------------
package deco_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic DEC_SINGLE = 1'b0;
    localparam logic DEC_SWEEP  = 1'b1;

    // The helper works on a fixed maximum width so it can live in a
    // non-parameterised package; callers size-cast the result down.
    localparam int MAX_IN_W  = 8;
    localparam int MAX_OUT_W = 2 ** MAX_IN_W;

    // Returns a MAX_OUT_W vector with exactly one bit set.
    //   msb_first = 1 : code 0 selects bit (2**in_w)-1 (legacy ordering)
    //   msb_first = 0 : code k selects bit k
    // Bits at and above 2**in_w are always zero.
    function automatic logic [MAX_OUT_W-1:0] onehot(
        input logic [MAX_IN_W-1:0] code,
        input int unsigned         in_w,
        input bit                  msb_first
    );
        logic [MAX_OUT_W-1:0] res;
        logic [MAX_IN_W-1:0]  top;
        logic [MAX_IN_W-1:0]  idx;
        res = '0;
        top = MAX_IN_W'((32'd1 << in_w) - 32'd1);
        // For code < 2**in_w, (top - code) mirrors the position within the
        // in_w-bit output range.
        idx = msb_first ? (top - code) : code;
        res[idx] = 1'b1;
        return res;
    endfunction

endpackage : deco_pkg

// File: rtl/deco_onehot_core.sv
// -----------------------------------------------------------------------------
// deco_onehot_core
//
// Purely combinational IN_W -> 2**IN_W one-hot decoder.
//
// Parameters:
//   IN_W      : code width (1 .. deco_pkg::MAX_IN_W)
//   MSB_FIRST : 1 -> code 0 drives oh[OUT_W-1]; 0 -> code k drives oh[k]
//
// Ports:
//   code : in  IN_W   code to decode
//   oh   : out OUT_W  one-hot result (exactly one bit set)
// -----------------------------------------------------------------------------
module deco_onehot_core
    import deco_pkg::*;
#(
    parameter  int IN_W      = 3,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int OUT_W     = 2 ** IN_W
) (
    input  logic [IN_W-1:0]  code,
    output logic [OUT_W-1:0] oh
);

    assign oh = OUT_W'(deco_pkg::onehot(MAX_IN_W'(code), IN_W, MSB_FIRST));

endmodule : deco_onehot_core

// File: rtl/deco_onehot_seq.sv
// -----------------------------------------------------------------------------
// deco_onehot_seq
//
// Registered N-to-2**N one-hot decoder with valid/ready on both sides and a
// sweep mode that emits a run of consecutive codes for one request.
//
// Parameters:
//   IN_W      : code width; OUT_W = 2**IN_W is derived
//   MSB_FIRST : 1 -> code 0 drives out_onehot[OUT_W-1]; 0 -> code k drives bit k
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : request present
//   in_ready    : request accepted when in_valid && in_ready
//   in_code     : start code
//   in_mode     : DEC_SINGLE (one beat) or DEC_SWEEP
//   in_len      : sweep beats minus one (ignored for DEC_SINGLE)
//   out_valid   : beat present
//   out_ready   : downstream takes beat when out_valid && out_ready
//   out_onehot  : one-hot of out_code, zero when out_valid = 0
//   out_code    : code of the current beat
//   out_last    : final beat of the request
//   busy        : FSM not in IDLE (also serves as the state debug view)
//
// A request is accepted in IDLE, or on the edge where the last beat of the
// current request is taken, so back-to-back requests stream without bubbles.
// -----------------------------------------------------------------------------
module deco_onehot_seq
    import deco_pkg::*;
#(
    parameter  int IN_W      = 3,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int OUT_W     = 2 ** IN_W
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_mode,
    input  logic [IN_W-1:0]  in_len,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [IN_W-1:0]  out_code,
    output logic             out_last,

    output logic             busy
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [IN_W-1:0]   code_q,  code_d;
    logic [IN_W-1:0]   rem_q,   rem_d;    // beats left after the current one
    logic              valid_q, valid_d;
    logic              last_q,  last_d;

    logic              take;
    logic              accept;
    logic [OUT_W-1:0]  core_oh;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign take     = valid_q && out_ready;

    // Ready depends only on state, out_ready and rst, never on in_valid.
    assign in_ready = !rst && ((state_q == IDLE) || (take && last_q));
    assign accept   = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rem_d   = rem_q;
        valid_d = valid_q;

        if (take) begin
            if (!last_q) begin
                // Natural wrap of the IN_W-bit adder gives the modulo-OUT_W step.
                code_d = code_q + IN_W'(1);
                rem_d  = rem_q - IN_W'(1);
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end

        // A new request overrides the return to IDLE on a taken last beat.
        if (accept) begin
            state_d = EMIT;
            valid_d = 1'b1;
            code_d  = in_code;
            rem_d   = (in_mode == DEC_SWEEP) ? in_len : '0;
        end

        last_d = (state_d == EMIT) && (rem_d == '0);
    end

    // -------------------------------------------------------------------------
    // Registers (reset wins over any simultaneous handshake)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    deco_onehot_core #(
        .IN_W      (IN_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .code (code_q),
        .oh   (core_oh)
    );

    assign out_valid  = valid_q;
    assign out_code   = code_q;
    assign out_last   = last_q;
    assign out_onehot = valid_q ? core_oh : '0;
    assign busy       = (state_q != IDLE);

endmodule : deco_onehot_seq

// File: tb/tb_deco_onehot_seq.sv
// -----------------------------------------------------------------------------
// tb_deco_onehot_seq
//
// Main instance: IN_W=3, MSB_FIRST=1. Second instance: IN_W=4, MSB_FIRST=0.
// Each request is expanded into its full list of expected beats
// {last, code, onehot} pushed on exp_q; beats are checked at the negedge.
// -----------------------------------------------------------------------------
module tb_deco_onehot_seq;

    localparam int IN_W  = 3;
    localparam int OUT_W = 8;
    localparam int BW    = 1 + IN_W + OUT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic [IN_W-1:0]  in_code   = '0;
    logic             in_mode   = 1'b0;
    logic [IN_W-1:0]  in_len    = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_onehot;
    logic [IN_W-1:0]  out_code;
    logic             out_last;
    logic             busy;

    deco_onehot_seq #(.IN_W(3), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_mode    (in_mode),
        .in_len     (in_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .out_last   (out_last),
        .busy       (busy)
    );

    logic        in_valid4 = 1'b0;
    logic [3:0]  in_code4  = '0;
    logic        in_ready4;
    logic        out_valid4;
    logic [15:0] out_onehot4;
    logic [3:0]  out_code4;
    logic        out_last4;
    logic        busy4;

    deco_onehot_seq #(.IN_W(4), .MSB_FIRST(1'b0)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_code    (in_code4),
        .in_mode    (1'b0),
        .in_len     (4'd0),
        .out_valid  (out_valid4),
        .out_ready  (1'b1),
        .out_onehot (out_onehot4),
        .out_code   (out_code4),
        .out_last   (out_last4),
        .busy       (busy4)
    );

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expand one request into its beats from the rules: consecutive codes
    // modulo 8, len+1 beats for a sweep, one beat for a decode.
    task automatic push_request(input logic [IN_W-1:0] code, input logic mode, input logic [IN_W-1:0] len);
        int n;
        int c;
        logic [OUT_W-1:0] oh;
        n = mode ? int'(len) + 1 : 1;
        for (int b = 0; b < n; b++) begin
            c  = (int'(code) + b) % OUT_W;
            oh = OUT_W'(1) << (OUT_W - 1 - c);
            exp_q.push_back({(b == n - 1), IN_W'(c), oh});
        end
    endtask

    // ---------------- driver + per-cycle model ----------------
    // Inputs change just after the rising edge; outputs are checked at the
    // falling edge, then the model advances for the coming rising edge.
    task automatic cycle(input logic r, input logic iv, input logic [IN_W-1:0] c,
                         input logic m, input logic [IN_W-1:0] l, input logic ordy);
        logic exp_valid, exp_ready, take, accept;
        logic [BW-1:0] beat;
        @(posedge clk);
        #1;
        rst = r; in_valid = iv; in_code = c; in_mode = m; in_len = l; out_ready = ordy;
        @(negedge clk);
        exp_valid = (exp_q.size() != 0);
        exp_ready = !r && (!exp_valid || (ordy && exp_q.size() == 1));
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        check_eq("busy", {31'd0, busy}, {31'd0, exp_valid});
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        if (exp_valid) begin
            beat = exp_q[0];
            check_eq("out_onehot", 32'(out_onehot), 32'(beat[OUT_W-1:0]));
            check_eq("out_code", 32'(out_code), 32'(beat[OUT_W+IN_W-1:OUT_W]));
            check_eq("out_last", {31'd0, out_last}, {31'd0, beat[BW-1]});
        end else begin
            check_eq("onehot_idle", 32'(out_onehot), 32'd0);
        end
        take   = exp_valid && ordy;
        accept = iv && exp_ready;
        if (r) begin
            exp_q.delete();
        end else begin
            if (take) void'(exp_q.pop_front());
            if (accept) push_request(c, m, l);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        check_eq("rst_out_code", 32'(out_code), 32'd0);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_onehot", 32'(out_onehot), 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        idle(2);

        // Decode code 0
        cycle(1'b0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1);
        cycle(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        check_eq("dec0_oh", 32'(out_onehot), 32'h80);
        check_eq("dec0_last", {31'd0, out_last}, 32'd1);
        check_eq("dec0_in_ready", {31'd0, in_ready}, 32'd1);
        idle(1);

        // Decode code 5 with three stall cycles
        cycle(1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 3'd1, 1'b1, 3'd7, 1'b0);
            check_eq("stall_oh", 32'(out_onehot), 32'h04);
            check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("stall_busy", {31'd0, busy}, 32'd1);
        end
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("stall_take_oh", 32'(out_onehot), 32'h04);
        idle(1);
        check_eq("stall_idle_busy", {31'd0, busy}, 32'd0);

        // Sweep code 6, len 3 -> codes 6,7,0,1
        cycle(1'b0, 1'b1, 3'd6, 1'b1, 3'd3, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("sweep_b0_oh", 32'(out_onehot), 32'h02);
        check_eq("sweep_b0_last", {31'd0, out_last}, 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("sweep_b2_oh", 32'(out_onehot), 32'h80);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("sweep_b3_oh", 32'(out_onehot), 32'h40);
        check_eq("sweep_b3_last", {31'd0, out_last}, 32'd1);
        idle(1);

        // Back-to-back: decode 2, then sweep 0 len 1
        cycle(1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1);
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1);
        check_eq("b2b_code2", 32'(out_code), 32'd2);
        check_eq("b2b_ready_on_last", {31'd0, in_ready}, 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("b2b_code0", 32'(out_code), 32'd0);
        check_eq("b2b_no_bubble", {31'd0, out_valid}, 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("b2b_code1_last", {31'd0, out_last}, 32'd1);
        idle(1);

        // Reset on the 2nd beat of a full sweep
        cycle(1'b0, 1'b1, 3'd3, 1'b1, 3'd7, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 3'd1, 1'b0, '0, 1'b1);
        check_eq("rst_mid_code", 32'(out_code), 32'd4);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        check_eq("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_mid_oh", 32'(out_onehot), 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        idle(3);

        // Full sweep visits every code once
        cycle(1'b0, 1'b1, 3'd5, 1'b1, 3'd7, 1'b1);
        idle(9);

        // IN_W=4, MSB_FIRST=0 instance
        in_valid4 = 1'b1;
        in_code4  = 4'd9;
        idle(1);
        in_valid4 = 1'b0;
        check_eq("w4_dec9_oh", 32'(out_onehot4), 32'h0200);
        check_eq("w4_dec9_code", 32'(out_code4), 32'd9);
        check_eq("w4_dec9_last", {31'd0, out_last4}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] c4;
            c4 = 4'($urandom_range(0, 15));
            in_valid4 = 1'b1;
            in_code4  = c4;
            idle(1);
            in_valid4 = 1'b0;
            check_eq("w4_rand_valid", {31'd0, out_valid4}, 32'd1);
            check_eq("w4_rand_oh", 32'(out_onehot4), 32'd1 << c4);
        end
        idle(2);
        check_eq("w4_idle_busy", {31'd0, busy4}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 9) < 6),
                  IN_W'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  IN_W'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 7));
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_deco_onehot_seq
